// File: rtl/package_settings_V1.sv
// Shared settings for the trapezoidal filter datapath and its run/configuration sequencer.
package package_settings_V1;

  localparam int SIZE_OUT_DATA = 16;

  localparam int PAR_W     = 8;
  localparam int TS_W      = 32;
  localparam int PIPE_LAT  = 5;
  localparam int FLUSH_CYC = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    WARM  = 3'd2,
    ARMED = 3'd3,
    PEAK  = 3'd4,
    EMIT  = 3'd5,
    HOLD  = 3'd6
  } trap_state_t;

  typedef struct packed {
    logic [PAR_W-1:0] k;
    logic [PAR_W-1:0] l;
    logic [PAR_W-1:0] m;
  } trap_cfg_t;

endpackage

// File: rtl/trap_peak_capture.sv
// Peak amplitude/timestamp tracker for one pulse window; the pile-up flag is built only
// when TRAP_PILEUP_DETECT_EN is defined, otherwise ev_pileup is a constant 0.
module trap_peak_capture
  import package_settings_V1::*;
#(
  parameter int DATA_W  = SIZE_OUT_DATA,
  parameter int STAMP_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en,
  input  logic               done,
  input  logic [DATA_W-1:0]  data,
  input  logic [STAMP_W-1:0] ts,
`ifdef TRAP_PILEUP_DETECT_EN
  input  logic               above,
`endif
  output logic [DATA_W-1:0]  amp,
  output logic [STAMP_W-1:0] amp_ts,
  output logic               pileup
);

  logic [DATA_W-1:0]  max_r, max_n;
  logic [STAMP_W-1:0] ts_r, ts_n;

  // Strict compare keeps the earliest sample on ties; clear seeds with the crossing sample.
  always_comb begin
    max_n = max_r;
    ts_n  = ts_r;
    if (clear) begin
      max_n = data;
      ts_n  = ts;
    end else if (en && (data > max_r)) begin
      max_n = data;
      ts_n  = ts;
    end
  end

  // Results are published on the window's last sample so that sample is included.
  always_ff @(posedge clk) begin
    if (!reset) begin
      max_r  <= '0;
      ts_r   <= '0;
      amp    <= '0;
      amp_ts <= '0;
    end else begin
      max_r <= max_n;
      ts_r  <= ts_n;
      if (done) begin
        amp    <= max_n;
        amp_ts <= ts_n;
      end
    end
  end

`ifdef TRAP_PILEUP_DETECT_EN
  logic dip_r, dip_n, pile_r, pile_n;

  always_comb begin
    dip_n  = dip_r;
    pile_n = pile_r;
    if (clear) begin
      dip_n  = 1'b0;
      pile_n = 1'b0;
    end else if (en) begin
      if (!above)
        dip_n = 1'b1;
      else if (dip_r)
        pile_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dip_r  <= 1'b0;
      pile_r <= 1'b0;
      pileup <= 1'b0;
    end else begin
      dip_r  <= dip_n;
      pile_r <= pile_n;
      if (done)
        pileup <= pile_n;
    end
  end
`else
  assign pileup = 1'b0;
`endif

endmodule

// File: rtl/trap_run_ctrl.sv
// Run/configuration sequencer for the trapezoidal shaping filter: flush, warm-up, arm,
// peak capture and event hand-off. Optional pile-up detection: TRAP_PILEUP_DETECT_EN.
module trap_run_ctrl
  import package_settings_V1::*;
#(
  parameter int K_DEF     = 4,
  parameter int L_DEF     = 8,
  parameter int M_DEF     = 16,
  parameter int PAR_W     = package_settings_V1::PAR_W,
  parameter int PIPE_LAT  = package_settings_V1::PIPE_LAT,
  parameter int FLUSH_CYC = package_settings_V1::FLUSH_CYC,
  parameter int TS_W      = package_settings_V1::TS_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     cfg_wr,
  input  logic [PAR_W-1:0]         cfg_k,
  input  logic [PAR_W-1:0]         cfg_l,
  input  logic [PAR_W-1:0]         cfg_m,
  output logic                     cfg_ready,
  input  logic [SIZE_OUT_DATA-1:0] threshold,
  output logic                     filt_rst_n,
  output logic [PAR_W-1:0]         filt_k,
  output logic [PAR_W-1:0]         filt_l,
  output logic [PAR_W-1:0]         filt_m,
  input  logic [SIZE_OUT_DATA-1:0] filt_data,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [SIZE_OUT_DATA-1:0] ev_amp,
  output logic [TS_W-1:0]          ev_ts,
  output logic                     ev_pileup,
  output logic [2:0]               state_o
);

  // Two spare bits keep k+l+PIPE_LAT exact for any k, l.
  localparam int CNT_W = PAR_W + 2;

  trap_state_t       state;
  logic [TS_W-1:0]   ts;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  warm_len, win_len;
  logic              above, cfg_take, win_one, win_last;
  logic              cap_clear, cap_en, cap_done;

  assign warm_len  = CNT_W'(filt_k) + CNT_W'(filt_l) + CNT_W'(PIPE_LAT);
  assign win_len   = CNT_W'(filt_k) + CNT_W'(filt_l);
  assign win_one   = (win_len <= CNT_W'(1));
  assign win_last  = ((cnt + CNT_W'(1)) >= win_len);
  assign above     = (filt_data > threshold);

  assign cfg_ready  = (state == IDLE) || (state == ARMED);
  assign cfg_take   = cfg_wr && cfg_ready;
  assign filt_rst_n = !((state == IDLE) || (state == FLUSH));
  assign ev_valid   = (state == EMIT);
  assign state_o    = state;

  // The crossing sample is window cycle 1; a reconfiguration in ARMED wins over it.
  assign cap_clear = (state == ARMED) && run && !cfg_take && above;
  assign cap_en    = (state == PEAK);
  assign cap_done  = (cap_clear && win_one) || ((state == PEAK) && run && win_last);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      ts     <= '0;
      filt_k <= PAR_W'(K_DEF);
      filt_l <= PAR_W'(L_DEF);
      filt_m <= PAR_W'(M_DEF);
    end else begin
      ts <= ts + TS_W'(1);
      if (cfg_take) begin
        filt_k <= cfg_k;
        filt_l <= cfg_l;
        filt_m <= cfg_m;
      end
      case (state)
        IDLE: begin
          if (run) begin
            state <= FLUSH;
            cnt   <= '0;
          end
        end
        FLUSH: begin
          if (!run)
            state <= IDLE;
          else if ((cnt + CNT_W'(1)) >= CNT_W'(FLUSH_CYC)) begin
            state <= WARM;
            cnt   <= '0;
          end else
            cnt <= cnt + CNT_W'(1);
        end
        WARM: begin
          if (!run)
            state <= IDLE;
          else if ((cnt + CNT_W'(1)) >= warm_len)
            state <= ARMED;
          else
            cnt <= cnt + CNT_W'(1);
        end
        ARMED: begin
          if (!run)
            state <= IDLE;
          else if (cfg_take) begin
            state <= FLUSH;
            cnt   <= '0;
          end else if (above) begin
            state <= win_one ? EMIT : PEAK;
            cnt   <= CNT_W'(1);
          end
        end
        PEAK: begin
          if (!run)
            state <= IDLE;
          else if (win_last)
            state <= EMIT;
          else
            cnt <= cnt + CNT_W'(1);
        end
        EMIT: begin
          if (ev_ready)
            state <= run ? HOLD : IDLE;
        end
        HOLD: begin
          if (!run)
            state <= IDLE;
          else if (!above)
            state <= ARMED;
        end
        default: state <= IDLE;
      endcase
    end
  end

  trap_peak_capture #(
    .DATA_W (SIZE_OUT_DATA),
    .STAMP_W(TS_W)
  ) u_capture (
    .clk   (clk),
    .reset (reset),
    .clear (cap_clear),
    .en    (cap_en),
    .done  (cap_done),
    .data  (filt_data),
    .ts    (ts),
`ifdef TRAP_PILEUP_DETECT_EN
    .above (above),
`endif
    .amp   (ev_amp),
    .amp_ts(ev_ts),
    .pileup(ev_pileup)
  );

endmodule

// File: tb/tb_trap_run_ctrl.sv
// Scoreboard bench for trap_run_ctrl: pulses are predicted from the window rules and
// compared by a decoupled monitor at each ev_valid/ev_ready transfer.
module tb_trap_run_ctrl;
  import package_settings_V1::*;

  localparam int DW  = SIZE_OUT_DATA;
  localparam int PW  = 8;
  localparam int TSW = 10;

  logic           clk = 1'b0;
  logic           reset, run, cfg_wr, cfg_ready, filt_rst_n;
  logic [PW-1:0]  cfg_k, cfg_l, cfg_m, filt_k, filt_l, filt_m;
  logic [DW-1:0]  threshold, filt_data, ev_amp;
  logic           ev_valid, ev_pileup;
  logic           ev_ready = 1'b0;
  logic [TSW-1:0] ev_ts;
  logic [2:0]     state_o;

  trap_run_ctrl #(.TS_W(TSW)) dut (
    .clk(clk), .reset(reset), .run(run), .cfg_wr(cfg_wr),
    .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m), .cfg_ready(cfg_ready),
    .threshold(threshold), .filt_rst_n(filt_rst_n),
    .filt_k(filt_k), .filt_l(filt_l), .filt_m(filt_m),
    .filt_data(filt_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_amp(ev_amp), .ev_ts(ev_ts), .ev_pileup(ev_pileup), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]  amp;
    logic [TSW-1:0] ts;
    logic           pile;
  } ev_t;

  ev_t            exp_q[$];
  int unsigned    n_tests = 0, n_fail = 0;
  int unsigned    stall = 0, hs_count = 0, cycles = 0;
  int unsigned    cur_k = 4, cur_l = 8, thr = 100;
  logic [TSW-1:0] tsm;

  // Reference timestamp: zero under reset, +1 per cycle, modulo 2^TSW.
  always @(posedge clk) begin
    if (!reset) tsm <= '0;
    else        tsm <= tsm + 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: decides ev_ready for the coming edge, then scores any transfer it implies.
  logic           pv = 1'b0, ph = 1'b0, ppile;
  logic [DW-1:0]  pamp;
  logic [TSW-1:0] pts;
  always @(negedge clk) begin
    ev_t e;
    logic hs;
    if (!reset) begin
      ev_ready = 1'b0;
      pv = 1'b0;
      ph = 1'b0;
    end else begin
      if (pv && !ph) begin
        check("hold_valid", ev_valid, 1);
        check("hold_amp", ev_amp, pamp);
        check("hold_ts", ev_ts, pts);
        check("hold_pileup", ev_pileup, ppile);
      end
      if (ev_valid && stall > 0) begin
        ev_ready = 1'b0;
        stall--;
      end else begin
        ev_ready = ($urandom_range(0, 3) != 0);
      end
      hs = ev_valid && ev_ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("ev_amp", ev_amp, e.amp);
          check("ev_ts", ev_ts, e.ts);
          check("ev_pileup", ev_pileup, e.pile);
        end
        hs_count++;
      end
      pv = ev_valid; ph = hs; pamp = ev_amp; pts = ev_ts; ppile = ev_pileup;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycles++;
  endtask

  task automatic set_thr(input int unsigned t);
    thr = t;
    threshold = DW'(t);
  endtask

  task automatic bringup(input int unsigned exp_warm);
    int unsigned n;
    n = 0;
    while (state_o == IDLE && n < 20) begin tick(); n++; end
    n = 0;
    while (state_o == FLUSH && !filt_rst_n && n < 50) begin tick(); n++; end
    check("flush_len", n, FLUSH_CYC);
    n = 0;
    while (state_o == WARM && filt_rst_n && n < 1000) begin tick(); n++; end
    check("warm_len", n, exp_warm);
    check("armed_state", state_o, ARMED);
    check("armed_cfg_ready", cfg_ready, 1);
  endtask

  task automatic cfg_update(input int unsigned k, input int unsigned l, input int unsigned m);
    check("cfg_ready_armed", cfg_ready, 1);
    cfg_k = PW'(k); cfg_l = PW'(l); cfg_m = PW'(m); cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    filt_data = '0;
    check("cfg_k", filt_k, k);
    check("cfg_l", filt_l, l);
    check("cfg_m", filt_m, m);
    check("cfg_to_flush", state_o, FLUSH);
    cur_k = k; cur_l = l;
    bringup(k + l + PIPE_LAT);
  endtask

  function automatic int win_n();
    return (cur_k + cur_l == 0) ? 1 : int'(cur_k + cur_l);
  endfunction

  // Crossing sample, window body, then samples still above threshold (never retrigger).
  task automatic gen_pulse(output logic [DW-1:0] smp[$]);
    smp.delete();
    smp.push_back(DW'(thr + 1 + $urandom_range(0, 200)));
    for (int i = 1; i < win_n(); i++) smp.push_back(DW'($urandom_range(0, thr + 300)));
    repeat ($urandom_range(0, 3)) smp.push_back(DW'(thr + 1 + $urandom_range(0, 100)));
  endtask

  task automatic run_pulse(input logic [DW-1:0] smp[$], input bit cfg_peak, input bit emit_stop);
    int n, bi, guard;
    int unsigned old;
    logic [DW-1:0] best;
    bit dipped, pile;
    ev_t e;
    n = win_n();
    check("armed_pre", state_o, ARMED);
    best = smp[0]; bi = 0; dipped = 0; pile = 0;
    for (int i = 1; i < n; i++) begin
      if (smp[i] > best) begin best = smp[i]; bi = i; end
      if (smp[i] <= DW'(thr)) dipped = 1;
      else if (dipped) pile = 1;
    end
`ifndef TRAP_PILEUP_DETECT_EN
    pile = 0;
`endif
    e.amp = best; e.pile = pile; e.ts = '0;
    foreach (smp[i]) begin
      filt_data = smp[i];
      if (i == bi) e.ts = tsm;
      if (i == n - 1) exp_q.push_back(e);
      if (cfg_peak && i == 1) begin
        check("peak_state", state_o, PEAK);
        check("peak_cfg_ready", cfg_ready, 0);
        cfg_k = PW'(cur_k + 1); cfg_l = PW'(cur_l + 1); cfg_wr = 1'b1;
      end
      if (cfg_peak && i == 2) begin
        cfg_wr = 1'b0;
        check("peak_cfg_k_kept", filt_k, cur_k);
        check("peak_cfg_l_kept", filt_l, cur_l);
      end
      tick();
    end
    filt_data = DW'($urandom_range(0, thr));
    if (emit_stop) begin
      guard = 0;
      while (!ev_valid && guard < 100) begin tick(); guard++; end
      check("emit_reached", state_o, EMIT);
      run = 1'b0;
      old = hs_count;
      guard = 0;
      while (hs_count == old && guard < 100) begin tick(); guard++; end
      check("emit_run0_idle", state_o, IDLE);
    end else begin
      guard = 0;
      while (state_o != ARMED && guard < 300) begin tick(); guard++; end
      check("return_armed", state_o, ARMED);
    end
  endtask

  initial begin
    logic [DW-1:0] smp[$];
    int unsigned it, guard;
    reset = 1'b0; run = 1'b0; cfg_wr = 1'b0;
    cfg_k = '0; cfg_l = '0; cfg_m = '0; filt_data = '0;
    set_thr(100);
    repeat (3) tick();
    check("rst_state", state_o, IDLE);
    check("rst_filt_rst_n", filt_rst_n, 0);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_amp", ev_amp, 0);
    check("rst_ev_ts", ev_ts, 0);
    check("rst_ev_pileup", ev_pileup, 0);
    check("rst_k", filt_k, 4);
    check("rst_l", filt_l, 8);
    check("rst_m", filt_m, 16);
    check("rst_cfg_ready", cfg_ready, 1);
    reset = 1'b1;

    run = 1'b1;
    bringup(4 + 8 + PIPE_LAT);

    // Ramp pulse with a stalled consumer and an ignored write in PEAK.
    filt_data = 16'd0;  tick();
    filt_data = 16'd50; tick();
    check("below_thr_armed", state_o, ARMED);
    stall = 5;
    smp = {16'd150, 16'd300, 16'd280, 16'd260, 16'd240, 16'd220,
           16'd200, 16'd180, 16'd160, 16'd140, 16'd120, 16'd110};
    run_pulse(smp, 1'b1, 1'b0);

    cfg_update(2, 3, 20);

    // Dip inside the window, then samples above threshold during EMIT/HOLD.
    smp = {16'd150, 16'd250, 16'd90, 16'd200, 16'd120, 16'd300, 16'd180};
    run_pulse(smp, 1'b0, 1'b0);

    // run dropped in PEAK: capture discarded.
    check("armed_before_kill", state_o, ARMED);
    filt_data = 16'd500; tick();
    check("kill_peak", state_o, PEAK);
    run = 1'b0; filt_data = '0; tick();
    check("kill_idle", state_o, IDLE);
    check("kill_filt_rst_n", filt_rst_n, 0);
    repeat (3) tick();
    check("kill_no_event", ev_valid, 0);
    run = 1'b1;
    bringup(cur_k + cur_l + PIPE_LAT);

    // run dropped in EMIT: transfer still completes, then IDLE.
    stall = 3;
    smp = {16'd400, 16'd410, 16'd405, 16'd300, 16'd200, 16'd150};
    run_pulse(smp, 1'b0, 1'b1);
    run = 1'b1;
    bringup(cur_k + cur_l + PIPE_LAT);

    // k+l=0 with a simultaneous crossing: reconfiguration wins, window of one sample.
    filt_data = DW'(thr + 50);
    cfg_update(0, 0, 7);
    gen_pulse(smp);
    run_pulse(smp, 1'b0, 1'b0);

    it = 0;
    while (cycles < 2700 && it < 400) begin
      it++;
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 1) filt_data = DW'(thr + 5);
        cfg_update($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 255));
      end
      set_thr($urandom_range(20, 2000));
      filt_data = DW'($urandom_range(0, thr));
      repeat ($urandom_range(0, 4)) begin
        filt_data = DW'($urandom_range(0, thr));
        tick();
      end
      gen_pulse(smp);
      run_pulse(smp, 1'b0, 1'b0);
    end

    // Reset while an event is pending.
    check("armed_before_abort", state_o, ARMED);
    stall = 1000;
    gen_pulse(smp);
    foreach (smp[i]) begin filt_data = smp[i]; tick(); end
    guard = 0;
    while (!ev_valid && guard < 50) begin tick(); guard++; end
    check("abort_pending", ev_valid, 1);
    reset = 1'b0; tick();
    check("abort_ev_valid", ev_valid, 0);
    check("abort_state", state_o, IDLE);
    check("abort_ev_amp", ev_amp, 0);
    check("abort_ev_ts", ev_ts, 0);
    check("abort_k", filt_k, 4);
    stall = 0;
    reset = 1'b1;
    tick();

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
